// File: rtl/exibidor_sequencia_pkg.sv
// Shared state codes for the sequence player; the same 4-bit codes drive the HEX debug display.
package exibidor_sequencia_pkg;

  localparam logic [3:0] CodInicial = 4'd0;
  localparam logic [3:0] CodPrepara = 4'd1;
  localparam logic [3:0] CodAcende  = 4'd2;
  localparam logic [3:0] CodApaga   = 4'd3;
  localparam logic [3:0] CodProximo = 4'd4;
  localparam logic [3:0] CodFim     = 4'd5;

  typedef enum logic [3:0] {
    Inicial = CodInicial,
    Prepara = CodPrepara,
    Acende  = CodAcende,
    Apaga   = CodApaga,
    Proximo = CodProximo,
    Fim     = CodFim
  } estado_t;

endpackage

// File: rtl/contador_tempo.sv
// Generic up-counter for phase timing; fim is high while the count sits at M-1.
module contador_tempo #(
  parameter int unsigned M = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int unsigned W = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0] Ultimo = W'(M - 1);

  logic [W-1:0] valor_q, valor_d;

  always_comb begin
    valor_d = valor_q;
    if (zera) begin
      valor_d = '0;
    end else if (conta) begin
      valor_d = (valor_q == Ultimo) ? '0 : valor_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

  assign fim = (valor_q == Ultimo);

endmodule

// File: rtl/exibidor_sequencia.sv
// Plays memory positions 0..rodada on the LEDs, each lit for ON_CYCLES then dark for OFF_CYCLES.
module exibidor_sequencia #(
  parameter int unsigned ON_CYCLES  = 1000,
  parameter int unsigned OFF_CYCLES = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] rodada,
  input  logic [3:0] mem_dado,
  output logic [3:0] mem_endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  import exibidor_sequencia_pkg::*;

  estado_t    estado_q, estado_d;
  logic [3:0] rodada_q, endereco_q, valor_q;
  logic       fim_on, fim_off;

  // Each timer is held at zero outside its own phase, so it starts fresh on entry.
  contador_tempo #(.M(ON_CYCLES)) u_tempo_on (
    .clock(clock),
    .reset(reset),
    .zera (estado_q != Acende),
    .conta(estado_q == Acende),
    .fim  (fim_on)
  );

  contador_tempo #(.M(OFF_CYCLES)) u_tempo_off (
    .clock(clock),
    .reset(reset),
    .zera (estado_q != Apaga),
    .conta(estado_q == Apaga),
    .fim  (fim_off)
  );

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      Inicial: if (iniciar) estado_d = Prepara;
      Prepara: estado_d = Acende;
      Acende:  if (fim_on) estado_d = Apaga;
      // Final-position test happens before the increment, so the address never wraps.
      Apaga:   if (fim_off) estado_d = (endereco_q == rodada_q) ? Fim : Proximo;
      Proximo: estado_d = Prepara;
      Fim:     estado_d = Inicial;
      default: estado_d = Inicial;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= Inicial;
      rodada_q   <= '0;
      endereco_q <= '0;
      valor_q    <= '0;
    end else begin
      estado_q <= estado_d;
      if (estado_q == Inicial && iniciar) begin
        rodada_q   <= rodada;
        endereco_q <= '0;
      end
      if (estado_q == Prepara) valor_q <= mem_dado;
      if (estado_q == Proximo) endereco_q <= endereco_q + 4'd1;
    end
  end

  assign mem_endereco = endereco_q;
  assign leds         = (estado_q == Acende) ? valor_q : 4'd0;
  assign ocupado      = (estado_q != Inicial);
  assign pronto       = (estado_q == Fim);
  assign db_estado    = estado_q;

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Scoreboard bench: arithmetic timeline model per cycle plus queued lit/pronto events.
module tb_exibidor_sequencia;

  localparam int On = 3;
  localparam int Off = 2;
  localparam int P = On + Off + 2;
  localparam int EvLit = 0;
  localparam int EvPronto = 1;

  typedef struct {
    int         kind;
    int         t;
    logic [3:0] addr;
    logic [3:0] val;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [3:0] rodada = 4'd0;
  logic [3:0] mem_dado, mem_endereco, leds, db_estado;
  logic       ocupado, pronto;
  logic [3:0] mem [16];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  sbq[$];

  bit         run_valid = 1'b0;
  int         run_c0 = 0;
  int         run_r = 0;
  logic [3:0] run_prev = 4'd0;
  logic [3:0] run_mem [16];

  assign mem_dado = mem[mem_endereco];

  exibidor_sequencia #(.ON_CYCLES(On), .OFF_CYCLES(Off)) dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .rodada      (rodada),
    .mem_dado    (mem_dado),
    .mem_endereco(mem_endereco),
    .leds        (leds),
    .ocupado     (ocupado),
    .pronto      (pronto),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Expected {db_estado, mem_endereco, leds, ocupado, pronto} in cycle t.
  function automatic logic [13:0] model(input int t);
    int d, i, w, fim_t;
    logic [3:0] st, ix, lv;
    if (!run_valid || t <= run_c0) return {4'd0, run_prev, 4'd0, 2'b00};
    fim_t = run_c0 + 1 + run_r * P + On + Off + 1;
    ix = 4'(run_r);
    if (t > fim_t) return {4'd0, ix, 4'd0, 2'b00};
    if (t == fim_t) return {4'd5, ix, 4'd0, 2'b11};
    d = t - run_c0 - 1;
    i = d / P;
    w = d % P;
    if (w == 0) st = 4'd1;
    else if (w <= On) st = 4'd2;
    else if (w <= On + Off) st = 4'd3;
    else st = 4'd4;
    lv = (st == 4'd2) ? run_mem[i] : 4'd0;
    return {st, 4'(i), lv, 2'b10};
  endfunction

  // Monitor: per-cycle trace check and scoreboard pops on lit/pronto events.
  initial begin
    logic [13:0] got, exp_v;
    logic [3:0]  prev_est;
    ev_t         e;
    int          kind;
    prev_est = 4'd0;
    forever begin
      @(negedge clock);
      got = {db_estado, mem_endereco, leds, ocupado, pronto};
      exp_v = model(cyc);
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL trace cycle=%0d got est=%0d addr=%0d leds=%b ocup=%b pronto=%b expected est=%0d addr=%0d leds=%b ocup=%b pronto=%b",
                 cyc, got[13:10], got[9:6], got[5:2], got[1], got[0],
                 exp_v[13:10], exp_v[9:6], exp_v[5:2], exp_v[1], exp_v[0]);
      end
      if ((db_estado == 4'd2 && prev_est != 4'd2) || pronto === 1'b1) begin
        kind = (pronto === 1'b1) ? EvPronto : EvLit;
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL event cycle=%0d got kind=%0d with no event expected", cyc, kind);
        end else begin
          e = sbq.pop_front();
          if (e.kind != kind || e.t != cyc ||
              (kind == EvLit && (e.addr != mem_endereco || e.val != leds))) begin
            failures++;
            $display("FAIL event got kind=%0d cycle=%0d addr=%0d leds=%b expected kind=%0d cycle=%0d addr=%0d leds=%b",
                     kind, cyc, mem_endereco, leds, e.kind, e.t, e.addr, e.val);
          end
        end
      end
      prev_est = db_estado;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_reset_state(input string name);
    checks++;
    if ({leds, db_estado, mem_endereco, ocupado, pronto} !== 14'd0) begin
      failures++;
      $display("FAIL %s got leds=%b est=%0d addr=%0d ocup=%b pronto=%b expected all zero",
               name, leds, db_estado, mem_endereco, ocupado, pronto);
    end
  endtask

  // Called just after a negedge; returns just after the negedge of the cycle following FIM.
  // A nonzero abort_off asserts reset in that cycle offset from the start.
  task automatic start_run(input int r, input bit hold, input int abort_off);
    int  fim_t;
    ev_t e;
    run_prev  = run_valid ? 4'(run_r) : 4'd0;
    run_c0    = cyc;
    run_r     = r;
    run_valid = 1'b1;
    for (int k = 0; k < 16; k++) run_mem[k] = mem[k];
    rodada  = 4'(r);
    iniciar = 1'b1;
    for (int k = 0; k <= r; k++) begin
      e.kind = EvLit; e.t = run_c0 + 2 + k * P; e.addr = 4'(k); e.val = mem[k];
      sbq.push_back(e);
    end
    fim_t = run_c0 + 1 + r * P + On + Off + 1;
    e.kind = EvPronto; e.t = fim_t; e.addr = 4'(r); e.val = 4'd0;
    sbq.push_back(e);
    for (int t = run_c0 + 1; t <= fim_t; t++) begin
      @(negedge clock);
      if (abort_off > 0 && t == run_c0 + abort_off) begin
        iniciar = 1'b0;
        #1 reset = 1'b0;
        #1 check_reset_state("reset_mid_run");
        run_valid = 1'b0;
        run_prev  = 4'd0;
        sbq.delete();
        idle(3);
        reset = 1'b1;
        return;
      end
      rodada  = 4'($urandom);
      iniciar = hold || (t >= run_c0 + 2 && t <= fim_t - 2 && $urandom_range(3) == 0);
    end
    @(negedge clock);
    iniciar = hold;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = 4'd0;
    #1 reset = 1'b0;
    #1 check_reset_state("reset_state");
    idle(2);
    reset = 1'b1;
    idle(1);

    mem[0] = 4'b0010;
    start_run(0, 1'b0, 0);
    idle(3);

    mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'b1000;
    start_run(2, 1'b0, 0);
    idle(2);

    for (int k = 0; k < 16; k++) mem[k] = 4'(15 - k);
    start_run(15, 1'b0, 0);
    idle(2);

    for (int k = 0; k < 16; k++) mem[k] = 4'(k + 3);
    start_run(3, 1'b0, 2 + P + 1);
    idle(2);
    start_run(1, 1'b0, 0);
    idle(1);

    mem[0] = 4'b1001; mem[1] = 4'b0110;
    start_run(1, 1'b1, 0);
    mem[2] = 4'b1111;
    start_run(2, 1'b0, 0);

    repeat (8) begin
      for (int k = 0; k < 16; k++) mem[k] = 4'($urandom);
      idle($urandom_range(3));
      start_run($urandom_range(15), 1'b0, 0);
    end
    idle(4);

    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending events expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
